// File: rtl/vend_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vend_pkg
// Brief    : Shared types and default timing constants for the dispense stage.
// Revision : 1.0
// ============================================================================
package vend_pkg;

  typedef enum logic [1:0] {
    BEV_NONE = 2'd0,
    BEV_A    = 2'd1,
    BEV_B    = 2'd2,
    BEV_C    = 2'd3
  } bev_code_t;

  // S_DONE_ONLY holds the single cycle between accepting an empty order and its done pulse.
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_BEV_WAIT  = 3'd1,
    S_CHG_WAIT  = 3'd2,
    S_CHG_PAY   = 3'd3,
    S_DONE_ONLY = 3'd4
  } seq_state_t;

  localparam int DEF_BEV_DELAY = 10;
  localparam int DEF_CHG_DELAY = 20;
  localparam int DEF_CHG_CHUNK = 100;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vend_delay_counter.sv
`default_nettype none
// ============================================================================
// Module   : vend_delay_counter
// Brief    : Loadable down-counter with zero flag, shared by both wait states.
// Revision : 1.0
// ============================================================================
module vend_delay_counter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/vend_dispense_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : vend_dispense_sequencer
// Brief    : Times beverage delivery and chunked change pay-out for one order.
// Revision : 1.0
// ============================================================================
module vend_dispense_sequencer
  import vend_pkg::*;
#(
  parameter int BEV_DELAY = DEF_BEV_DELAY,
  parameter int CHG_DELAY = DEF_CHG_DELAY,
  parameter int COIN_W    = 16,
  parameter int BEV_W     = 2,
  parameter int CHG_CHUNK = DEF_CHG_CHUNK
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [BEV_W-1:0]  req_beverage,
  input  logic [COIN_W-1:0] req_change,
  output logic [BEV_W-1:0]  beverage_out,
  output logic [COIN_W-1:0] change_out,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(max_int(BEV_DELAY, CHG_DELAY)) + 1;
  localparam logic [CNT_W-1:0]  c_bev_load = CNT_W'(BEV_DELAY - 1);
  localparam logic [CNT_W-1:0]  c_chg_load = CNT_W'(CHG_DELAY - 1);
  localparam logic [COIN_W-1:0] c_chunk    = COIN_W'(CHG_CHUNK);

  seq_state_t        r_state;
  logic [BEV_W-1:0]  r_bev;
  logic [COIN_W-1:0] r_remaining;
  logic [COIN_W-1:0] w_chunk;
  logic              w_accept;
  logic              w_load;
  logic [CNT_W-1:0]  w_load_val;
  logic              w_zero;

  // Ready stays low through the done cycle so orders are spaced by one idle cycle.
  assign req_ready = rst & (r_state == S_IDLE) & ~done;
  assign w_accept  = req_valid & req_ready;
  assign busy      = (r_state != S_IDLE);
  assign w_chunk   = (r_remaining > c_chunk) ? c_chunk : r_remaining;

  always_comb begin
    w_load     = 1'b0;
    w_load_val = c_bev_load;
    case (r_state)
      S_IDLE: begin
        if (w_accept && (req_beverage != '0)) begin
          w_load = 1'b1;
        end else if (w_accept && (req_change != '0)) begin
          w_load     = 1'b1;
          w_load_val = c_chg_load;
        end
      end
      S_BEV_WAIT: begin
        if (w_zero && (r_remaining != '0)) begin
          w_load     = 1'b1;
          w_load_val = c_chg_load;
        end
      end
      default: ;
    endcase
  end

  vend_delay_counter #(.W(CNT_W)) u_delay (
    .clk      (clk),
    .rst      (rst),
    .load     (w_load),
    .load_val (w_load_val),
    .zero     (w_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_bev        <= '0;
      r_remaining  <= '0;
      beverage_out <= '0;
      change_out   <= '0;
      done         <= 1'b0;
    end else begin
      beverage_out <= '0;
      change_out   <= '0;
      done         <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_bev       <= req_beverage;
            r_remaining <= req_change;
            if (req_beverage != '0)    r_state <= S_BEV_WAIT;
            else if (req_change != '0) r_state <= S_CHG_WAIT;
            else                       r_state <= S_DONE_ONLY;
          end
        end
        S_DONE_ONLY: begin
          done    <= 1'b1;
          r_state <= S_IDLE;
        end
        S_BEV_WAIT: begin
          if (w_zero) begin
            beverage_out <= r_bev;
            if (r_remaining != '0) begin
              r_state <= S_CHG_WAIT;
            end else begin
              done    <= 1'b1;
              r_state <= S_IDLE;
            end
          end
        end
        S_CHG_WAIT, S_CHG_PAY: begin
          if (w_zero || (r_state == S_CHG_PAY)) begin
            change_out  <= w_chunk;
            r_remaining <= r_remaining - w_chunk;
            if (w_chunk == r_remaining) begin
              done    <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_state <= S_CHG_PAY;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vend_dispense_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_vend_dispense_sequencer
// Brief    : Directed and random orders checked cycle by cycle against a timeline model.
// Revision : 1.0
// ============================================================================
module tb_vend_dispense_sequencer;
  import vend_pkg::*;

  localparam int N     = 10;
  localparam int M     = 20;
  localparam int CHUNK = 100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_beverage;
  logic [15:0] req_change;
  logic [1:0]  beverage_out;
  logic [15:0] change_out;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model: the one live order, as accept edge, contents and computed done edge.
  bit m_active = 1'b0;
  int m_a, m_d, m_bev, m_chg;

  vend_dispense_sequencer dut (
    .clk          (clk),
    .rst          (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_beverage (req_beverage),
    .req_change   (req_change),
    .beverage_out (beverage_out),
    .change_out   (change_out),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  function automatic bit model_ready(input int k);
    return (rst_n === 1'b1) && (!m_active || k > m_d);
  endfunction

  function automatic int order_done(input int a, input int bev, input int chg);
    if (bev == 0 && chg == 0) return a + 1;
    if (chg == 0) return a + N;
    return a + ((bev != 0) ? N : 0) + M + (chg + CHUNK - 1) / CHUNK - 1;
  endfunction

  task automatic check_all();
    int k, s, j, rem;
    int e_bev, e_chg, e_done, e_busy, e_rdy;
    k = cyc;
    e_bev = 0; e_chg = 0; e_done = 0; e_busy = 0;
    e_rdy = int'(model_ready(k));
    if ((rst_n === 1'b1) && m_active) begin
      if (m_bev != 0 && k == m_a + N) e_bev = m_bev;
      s = m_a + ((m_bev != 0) ? N : 0) + M;
      j = k - s;
      if (m_chg != 0 && j >= 0 && j * CHUNK < m_chg) begin
        rem   = m_chg - j * CHUNK;
        e_chg = (rem > CHUNK) ? CHUNK : rem;
      end
      e_done = (k == m_d) ? 1 : 0;
      e_busy = (k >= m_a && k < m_d) ? 1 : 0;
    end
    check_val("req_ready",    int'(req_ready),    e_rdy);
    check_val("beverage_out", int'(beverage_out), e_bev);
    check_val("change_out",   int'(change_out),   e_chg);
    check_val("done",         int'(done),         e_done);
    check_val("busy",         int'(busy),         e_busy);
  endtask

  task automatic step();
    bit acc;
    acc = model_ready(cyc) && (req_valid === 1'b1);
    @(posedge clk);
    cyc++;
    if (rst_n !== 1'b1) begin
      m_active = 1'b0;
    end else if (acc) begin
      m_active = 1'b1;
      m_a      = cyc;
      m_bev    = int'(req_beverage);
      m_chg    = int'(req_change);
      m_d      = order_done(m_a, m_bev, m_chg);
    end
    #1 check_all();
  endtask

  task automatic start_order(input int bev, input int chg);
    int guard = 0;
    while (!model_ready(cyc) && guard < 2000) begin
      step();
      guard++;
    end
    if (guard >= 2000) check_val("ready_bound", guard, 0);
    req_valid    = 1'b1;
    req_beverage = 2'(bev);
    req_change   = 16'(chg);
    step();
    req_valid    = 1'b0;
    req_beverage = 2'($urandom);
    req_change   = 16'($urandom);
  endtask

  task automatic run_until_idle();
    int guard = 0;
    while (m_active && cyc <= m_d && guard < 2000) begin
      step();
      guard++;
    end
    if (guard >= 2000) check_val("idle_bound", guard, 0);
    step();
  endtask

  initial begin
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_beverage = '0;
    req_change   = '0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    start_order(2, 0);     run_until_idle();
    start_order(1, 250);   run_until_idle();
    start_order(0, 40);    run_until_idle();
    start_order(0, 0);     run_until_idle();
    start_order(3, 100);   run_until_idle();
    start_order(0, 65535); run_until_idle();

    // Reset in the middle of a change wait must discard the order entirely.
    start_order(1, 250);
    repeat (15) step();
    rst_n    = 1'b0;
    m_active = 1'b0;
    #1 check_all();
    repeat (2) step();
    rst_n = 1'b1;
    repeat (25) step();

    // Next order held valid during busy is only taken once the first has finished.
    start_order(3, 120);
    req_valid    = 1'b1;
    req_beverage = 2'd2;
    req_change   = 16'd300;
    run_until_idle();
    req_valid    = 1'b0;
    req_beverage = 2'($urandom);
    req_change   = 16'($urandom);
    run_until_idle();

    for (int i = 0; i < 3000; i++) begin
      if (rst_n !== 1'b1) begin
        rst_n = 1'b1;
      end else if ($urandom_range(0, 499) == 0) begin
        rst_n    = 1'b0;
        m_active = 1'b0;
        #1 check_all();
      end
      req_valid    = ($urandom_range(0, 3) == 0);
      req_beverage = 2'($urandom);
      case ($urandom_range(0, 3))
        0:       req_change = 16'd0;
        1:       req_change = 16'($urandom_range(1, 99));
        2:       req_change = 16'($urandom_range(0, 999));
        default: req_change = 16'(CHUNK * $urandom_range(1, 5));
      endcase
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
